// File: rtl/digits_to_7seg_mux.sv
// digits_to_7seg_mux: time-multiplexed driver for an N-digit common-anode
// 7-segment display. Nibbles, enable mask and decimal points are captured
// into shadow registers on load; each digit gets a slot of REFRESH_DIV mclk
// cycles whose first cycle is blanked to suppress ghosting.
// Optional: `define LEADING_ZERO_BLANK_EN darkens leading zero digits (k>0)
// unless their decimal point is set.
// Ports:
//   mclk            system clock, rising edge
//   rst             asynchronous active-high reset
//   word_in         packed nibbles, digit k = word_in[4k+3:4k], digit 0 rightmost
//   display_mask_in per-digit enable
//   dp_in           per-digit decimal point
//   load            capture word_in/display_mask_in/dp_in
//   seg             segments {g,f,e,d,c,b,a}, registered
//   an              anode enables, registered
//   dp              decimal point, registered
//   slot_tick       high on the last cycle of each slot
module digits_to_7seg_mux #(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 50000,
  parameter bit ACTIVE_LOW  = 1'b1
) (
  input  logic                    mclk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] word_in,
  input  logic [NUM_DIGITS-1:0]   display_mask_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    load,
  output logic [6:0]              seg,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    dp,
  output logic                    slot_tick
);

  localparam int CW = $clog2(REFRESH_DIV);
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'h3F;  4'h1: hex7 = 7'h06;  4'h2: hex7 = 7'h5B;  4'h3: hex7 = 7'h4F;
      4'h4: hex7 = 7'h66;  4'h5: hex7 = 7'h6D;  4'h6: hex7 = 7'h7D;  4'h7: hex7 = 7'h07;
      4'h8: hex7 = 7'h7F;  4'h9: hex7 = 7'h6F;  4'hA: hex7 = 7'h77;  4'hB: hex7 = 7'h7C;
      4'hC: hex7 = 7'h39;  4'hD: hex7 = 7'h5E;  4'hE: hex7 = 7'h79;  default: hex7 = 7'h71;
    endcase
  endfunction

  logic [4*NUM_DIGITS-1:0] sh_word;
  logic [NUM_DIGITS-1:0]   sh_mask;
  logic [NUM_DIGITS-1:0]   sh_dp;
  logic [CW-1:0]           cnt, cnt_nxt;
  logic [IW-1:0]           idx, idx_nxt;
  logic [3:0]              slot_nib, live_nib, cur_nib;
  logic                    slot_en, live_en, cur_en;
  logic                    slot_dp, live_dp, cur_dp;
  logic [NUM_DIGITS-1:0]   eff_mask;
  logic [6:0]              seg_nxt;
  logic [NUM_DIGITS-1:0]   an_nxt;
  logic                    dp_nxt;
  logic                    tick_nxt;

  // Effective per-digit enable from the shadow registers.
`ifdef LEADING_ZERO_BLANK_EN
  logic zero_above;
  always_comb begin
    eff_mask   = sh_mask;
    zero_above = 1'b1;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      zero_above = zero_above & (sh_word[4*(NUM_DIGITS-1-i) +: 4] == 4'h0);
      if ((NUM_DIGITS-1-i) != 0 && zero_above && !sh_dp[NUM_DIGITS-1-i])
        eff_mask[NUM_DIGITS-1-i] = 1'b0;
    end
  end
`else
  always_comb eff_mask = sh_mask;
`endif

  // Outputs are registered, so everything below describes the cycle after
  // this edge. Cycle 0 of a slot uses the shadow directly (the slot register
  // is only being loaded on that edge); later cycles use the slot register,
  // so a load mid-slot never disturbs the digit being shown.
  always_comb begin
    cnt_nxt  = (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
    idx_nxt  = idx;
    if (cnt == CNT_LAST)
      idx_nxt = (idx == IDX_LAST) ? '0 : idx + 1'b1;
    tick_nxt = (cnt_nxt == CNT_LAST);

    live_nib = '0;
    live_en  = 1'b0;
    live_dp  = 1'b0;
    for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
      if (IW'(k) == idx) begin
        live_nib = sh_word[4*k +: 4];
        live_en  = eff_mask[k];
        live_dp  = sh_dp[k];
      end
    end

    cur_nib = (cnt == '0) ? live_nib : slot_nib;
    cur_en  = (cnt == '0) ? live_en  : slot_en;
    cur_dp  = (cnt == '0) ? live_dp  : slot_dp;

    seg_nxt = '0;
    an_nxt  = '0;
    dp_nxt  = 1'b0;
    if (cnt_nxt != '0 && cur_en) begin
      seg_nxt = hex7(cur_nib);
      dp_nxt  = cur_dp;
      for (int unsigned k = 0; k < NUM_DIGITS; k++)
        if (IW'(k) == idx) an_nxt[k] = 1'b1;
    end
  end

  always_ff @(posedge mclk or posedge rst) begin
    if (rst) begin
      sh_word   <= '0;
      sh_mask   <= '0;
      sh_dp     <= '0;
      cnt       <= '0;
      idx       <= '0;
      slot_nib  <= '0;
      slot_en   <= 1'b0;
      slot_dp   <= 1'b0;
      seg       <= ACTIVE_LOW ? '1 : '0;
      an        <= ACTIVE_LOW ? '1 : '0;
      dp        <= ACTIVE_LOW;
      slot_tick <= 1'b0;
    end else begin
      if (load) begin
        sh_word <= word_in;
        sh_mask <= display_mask_in;
        sh_dp   <= dp_in;
      end
      if (cnt == '0) begin
        slot_nib <= live_nib;
        slot_en  <= live_en;
        slot_dp  <= live_dp;
      end
      cnt       <= cnt_nxt;
      idx       <= idx_nxt;
      seg       <= ACTIVE_LOW ? ~seg_nxt : seg_nxt;
      an        <= ACTIVE_LOW ? ~an_nxt  : an_nxt;
      dp        <= ACTIVE_LOW ? ~dp_nxt  : dp_nxt;
      slot_tick <= tick_nxt;
    end
  end

endmodule

// File: tb/tb_digits_to_7seg_mux.sv
// Testbench for digits_to_7seg_mux (NUM_DIGITS=4, REFRESH_DIV=4, ACTIVE_LOW=1).
// Expected pin states come from a time-based model: elapsed cycles since
// reset release give slot, digit and phase; a snapshot of the shadow data is
// taken at phase 0 of every slot.
module tb_digits_to_7seg_mux;
  localparam int ND  = 4;
  localparam int DIV = 4;

  logic          mclk = 1'b0;
  logic          rst;
  logic [15:0]   word_in;
  logic [3:0]    display_mask_in;
  logic [3:0]    dp_in;
  logic          load;
  logic [6:0]    seg;
  logic [3:0]    an;
  logic          dp;
  logic          slot_tick;

  digits_to_7seg_mux #(.NUM_DIGITS(ND), .REFRESH_DIV(DIV), .ACTIVE_LOW(1'b1)) dut (
    .mclk(mclk), .rst(rst), .word_in(word_in), .display_mask_in(display_mask_in),
    .dp_in(dp_in), .load(load), .seg(seg), .an(an), .dp(dp), .slot_tick(slot_tick)
  );

  always #5 mclk = ~mclk;

  localparam logic [6:0] HEX [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                      7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  int n_assert = 0;
  int n_fail   = 0;
  int t;
  logic [15:0] m_word, s_word;
  logic [3:0]  m_mask, s_mask, m_dp, s_dp;

  task automatic chk(input string tag, input logic [6:0] obs, input logic [6:0] exp_v);
    n_assert++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s t=%0d observed=%h expected=%h", tag, t, obs, exp_v);
    end
  endtask

  // Check the current cycle against the model.
  task automatic check_now();
    int phase, digit;
    logic [3:0] nib;
    logic lit;
    phase = t % DIV;
    digit = (t / DIV) % ND;
    if (phase == 0) begin
      s_word = m_word; s_mask = m_mask; s_dp = m_dp;
    end
    nib = 4'((s_word >> (4*digit)) & 16'hF);
    lit = (phase != 0) && s_mask[digit];
`ifdef LEADING_ZERO_BLANK_EN
    if (digit > 0 && (s_word >> (4*digit)) == 16'h0 && !s_dp[digit]) lit = 1'b0;
`endif
    chk("seg", seg, lit ? ~HEX[nib] : 7'h7F);
    chk("an", {3'b0, an}, lit ? {3'b0, ~(4'b1 << digit)} : 7'h0F);
    chk("dp", {6'b0, dp}, lit ? {6'b0, ~s_dp[digit]} : 7'h01);
    chk("slot_tick", {6'b0, slot_tick}, (phase == DIV-1) ? 7'h01 : 7'h00);
  endtask

  // One cycle: check, present inputs for the coming edge, advance.
  task automatic cyc(input bit ld, input logic [15:0] w, input logic [3:0] m, input logic [3:0] d);
    check_now();
    load = ld; word_in = w; display_mask_in = m; dp_in = d;
    if (ld) begin m_word = w; m_mask = m; m_dp = d; end
    @(negedge mclk);
    t++;
    load = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, $urandom, $urandom, $urandom);
  endtask

  task automatic go_to(input int digit, input int phase);
    for (int i = 0; i < 40; i++) begin
      if (t % DIV == phase && (t / DIV) % ND == digit) return;
      idle(1);
    end
    n_assert++; n_fail++;
    $error("FAIL align t=%0d observed=not aligned expected=digit %0d phase %0d", t, digit, phase);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk("rst_seg", seg, 7'h7F);
    chk("rst_an", {3'b0, an}, 7'h0F);
    chk("rst_dp", {6'b0, dp}, 7'h01);
    chk("rst_tick", {6'b0, slot_tick}, 7'h00);
    repeat (2) @(negedge mclk);
    rst = 1'b0;
    t = 0; m_word = '0; m_mask = '0; m_dp = '0;
    s_word = '0; s_mask = '0; s_dp = '0;
  endtask

  initial begin
    load = 1'b0; word_in = '0; display_mask_in = '0; dp_in = '0; t = 0;
    @(negedge mclk);
    do_reset();
    idle(6);
    // Scan of 1234, all digits enabled.
    cyc(1'b1, 16'h1234, 4'hF, 4'h0);
    idle(24);
    // Mask and decimal points.
    cyc(1'b1, 16'h8888, 4'b0101, 4'b0001);
    idle(20);
    // Mid-slot load at phase 2 of digit 0.
    cyc(1'b1, 16'h1234, 4'hF, 4'h0);
    go_to(0, 2);
    cyc(1'b1, 16'hFFFF, 4'hF, 4'h0);
    idle(8);
    // Load coincident with slot_tick.
    go_to(1, 3);
    cyc(1'b1, 16'hAAAA, 4'hF, 4'h0);
    idle(6);
    // Leading-zero patterns (dark only with the blanking option).
    cyc(1'b1, 16'h0042, 4'hF, 4'h0);
    idle(18);
    cyc(1'b1, 16'h0000, 4'hF, 4'h0);
    idle(18);
    cyc(1'b1, 16'h0300, 4'hF, 4'b0010);
    idle(18);
    // Reset in the middle of a slot.
    go_to(2, 2);
    do_reset();
    idle(6);
    // Random loads.
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 4) == 0)
        cyc(1'b1, 16'($urandom), 4'($urandom), 4'($urandom));
      else
        idle(1);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
